// File: rtl/univ_shift_reg_pkg.sv
// Shared constants for the universal shift register: mode encodings and
// burst-engine FSM states.
package univ_shift_reg_pkg;

  // Operation encodings carried on the mode input
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Burst-shift engine states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage : univ_shift_reg_pkg

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for univ_shift_reg. The rot signal exists only when
// SHIFT_ROTATE_EN is defined.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [1:0]       mode;
  logic [WIDTH-1:0] par_in;
  logic             ser_in_r;
  logic             ser_in_l;
  logic             start;
  logic [CNT_W-1:0] shamt;
`ifdef SHIFT_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  // Requester side: drives the operation, observes the register
  modport master (
    output mode, par_in, ser_in_r, ser_in_l, start, shamt,
`ifdef SHIFT_ROTATE_EN
    output rot,
`endif
    input  q, busy, done
  );

  // Shift register side
  modport slave (
    input  mode, par_in, ser_in_r, ser_in_l, start, shamt,
`ifdef SHIFT_ROTATE_EN
    input  rot,
`endif
    output q, busy, done
  );

endinterface : univ_shift_reg_if

// File: rtl/univ_shift_reg_shift_bit_cell.sv
// One bit of the universal shift register: selects the next value among
// hold, lower neighbour (shift-left), upper neighbour (shift-right) and load.
module shift_bit_cell
  import univ_shift_reg_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       cur,
  input  logic       from_lo,
  input  logic       from_hi,
  input  logic       par,
  output logic       nxt
);

  // 4:1 next-value mux
  always_comb begin
    nxt = cur;
    case (sel)
      MODE_HOLD: nxt = cur;
      MODE_SHL:  nxt = from_lo;
      MODE_SHR:  nxt = from_hi;
      MODE_LOAD: nxt = par;
      default:   nxt = cur;
    endcase
  end

endmodule : shift_bit_cell

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift-left / shift-right / load) with a
// counted burst-shift engine. Optional macro SHIFT_ROTATE_EN adds the rot
// input, which wraps the outgoing edge bit back in instead of the serial input.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic               clk,
  input logic               reset,
  univ_shift_reg_if.slave   bus
);

  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Clamp the requested count to the register width; a longer burst would
  // only keep shifting serial bits through an already-flushed register.
  function automatic logic [CNT_W-1:0] sat_shamt(input logic [CNT_W-1:0] s);
    return (s > WIDTH_CNT) ? WIDTH_CNT : s;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_left_q, dir_left_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [1:0]       op;
  logic [CNT_W-1:0] n_sat;
  logic             lsb_in;
  logic             msb_in;

  assign n_sat = sat_shamt(bus.shamt);

  // Bits entering at the register edges: serial inputs or wrapped bits
`ifdef SHIFT_ROTATE_EN
  assign lsb_in = bus.rot ? q_q[WIDTH-1] : bus.ser_in_r;
  assign msb_in = bus.rot ? q_q[0]       : bus.ser_in_l;
`else
  assign lsb_in = bus.ser_in_r;
  assign msb_in = bus.ser_in_l;
`endif

  // Burst FSM next state, counter and the operation applied this edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    op         = MODE_HOLD;
    case (state_q)
      SHIFT: begin
        op    = dir_left_q ? MODE_SHL : MODE_SHR;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        if (bus.start && (bus.mode == MODE_SHL || bus.mode == MODE_SHR)) begin
          dir_left_d = (bus.mode == MODE_SHL);
          if (n_sat == '0) begin
            state_d = DONE;
          end else begin
            op      = bus.mode;
            cnt_d   = n_sat - CNT_ONE;
            state_d = (n_sat == CNT_ONE) ? DONE : SHIFT;
          end
        end else begin
          op = bus.mode;
        end
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // Per-bit next-value muxes; bit 0 and bit WIDTH-1 take the edge bits
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic lo_nb;
    logic hi_nb;
    if (i == 0) begin : g_lo_edge
      assign lo_nb = lsb_in;
    end else begin : g_lo_mid
      assign lo_nb = q_q[i-1];
    end
    if (i == WIDTH - 1) begin : g_hi_edge
      assign hi_nb = msb_in;
    end else begin : g_hi_mid
      assign hi_nb = q_q[i+1];
    end
    shift_bit_cell u_cell (
      .sel     (op),
      .cur     (q_q[i]),
      .from_lo (lo_nb),
      .from_hi (hi_nb),
      .par     (bus.par_in[i]),
      .nxt     (q_d[i])
    );
  end

  // State, counter, register contents and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      q_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_left_q <= dir_left_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      q_q        <= q_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg (WIDTH=8, CNT_W=4).
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  univ_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] q, input logic busy, input logic done);
    chk({tag, ".q"},    32'(bus.q),    32'(q));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    chk({tag, ".done"}, 32'(bus.done), 32'(done));
  endtask

  task automatic load(input logic [7:0] v);
    bus.mode   = 2'b11;
    bus.par_in = v;
    bus.start  = 1'b0;
    step();
    bus.mode   = 2'b00;
  endtask

  initial begin
    reset        = 1'b1;
    bus.mode     = 2'b00;
    bus.par_in   = '0;
    bus.ser_in_r = 1'b0;
    bus.ser_in_l = 1'b0;
    bus.start    = 1'b0;
    bus.shamt    = '0;
`ifdef SHIFT_ROTATE_EN
    bus.rot      = 1'b0;
`endif
    step();
    step();
    chk_st("reset", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;

    // 1. parallel load then hold
    load(8'hA5);
    chk("load", 32'(bus.q), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_st("hold", 8'hA5, 1'b0, 1'b0);
    end

    // 2. direct shifts
    bus.mode = 2'b01; bus.ser_in_r = 1'b1;
    step();
    chk("shl", 32'(bus.q), 32'h4B);
    load(8'hA5);
    bus.mode = 2'b10; bus.ser_in_l = 1'b0;
    step();
    chk("shr", 32'(bus.q), 32'h52);
    bus.ser_in_r = 1'b0;

    // 3. burst left 3 from 0x81; mode changed to hold while busy
    load(8'h81);
    bus.start = 1'b1; bus.mode = 2'b01; bus.shamt = 4'd3;
    step();
    bus.start = 1'b0; bus.mode = 2'b00;
    chk_st("b3.e1", 8'h02, 1'b1, 1'b0);
    step();
    chk_st("b3.e2", 8'h04, 1'b1, 1'b0);
    step();
    chk_st("b3.e3", 8'h08, 1'b0, 1'b1);
    step();
    chk_st("b3.after", 8'h08, 1'b0, 1'b0);

    // 4a. shamt=0: no shift, done next cycle
    bus.start = 1'b1; bus.mode = 2'b01; bus.shamt = 4'd0;
    step();
    bus.start = 1'b0; bus.mode = 2'b00;
    chk_st("b0", 8'h08, 1'b0, 1'b1);
    step();
    chk_st("b0.after", 8'h08, 1'b0, 1'b0);

    // 4b. shamt=12 saturates to 8: right shift 0xFF with zeros
    load(8'hFF);
    bus.start = 1'b1; bus.mode = 2'b10; bus.shamt = 4'd12; bus.ser_in_l = 1'b0;
    step();
    bus.start = 1'b0; bus.mode = 2'b00;
    chk_st("b12.e1", 8'h7F, 1'b1, 1'b0);
    for (int i = 2; i <= 7; i++) begin
      step();
      chk("b12.busy", 32'(bus.busy), 32'h1);
    end
    chk("b12.e7", 32'(bus.q), 32'h01);
    step();
    chk_st("b12.e8", 8'h00, 1'b0, 1'b1);

    // Back-to-back: start accepted while done is high
    bus.start = 1'b1; bus.mode = 2'b01; bus.shamt = 4'd1; bus.ser_in_r = 1'b1;
    step();
    bus.start = 1'b0; bus.mode = 2'b00; bus.ser_in_r = 1'b0;
    chk_st("b2b", 8'h01, 1'b0, 1'b1);
    step();

    // 5. reset mid-burst; mode/start/par_in ignored during SHIFT
    load(8'h81);
    bus.start = 1'b1; bus.mode = 2'b01; bus.shamt = 4'd5;
    step();
    chk_st("rst.e1", 8'h02, 1'b1, 1'b0);
    bus.mode = 2'b11; bus.par_in = 8'hFF;
    step();
    chk_st("rst.e2", 8'h04, 1'b1, 1'b0);
    bus.start = 1'b0; bus.mode = 2'b00;
    reset = 1'b1;
    step();
    chk_st("rst.abort", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_st("rst.idle", 8'h00, 1'b0, 1'b0);

`ifdef SHIFT_ROTATE_EN
    // 6. rotate, direct and burst
    load(8'h81);
    bus.rot = 1'b1; bus.mode = 2'b01;
    step();
    chk("rot.shl", 32'(bus.q), 32'h03);
    load(8'h81);
    bus.start = 1'b1; bus.mode = 2'b10; bus.shamt = 4'd4;
    step();
    bus.start = 1'b0; bus.mode = 2'b00;
    chk("rot.e1", 32'(bus.q), 32'hC0);
    step();
    step();
    step();
    chk_st("rot.e4", 8'h18, 1'b0, 1'b1);
    bus.rot = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_univ_shift_reg
